// File: rtl/sobel_pixel_packer.sv
// Sobel pixel packer: packs eight 8-bit pixels into 64-bit words tagged with a
// frame-relative word index, and tracks frame boundaries and length errors.
module sobel_pixel_packer #(
  parameter int unsigned FRAME_WORDS = 38400,
  parameter int unsigned IDX_WIDTH   = 20
) (
  input  logic                          data_clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [7:0]                    pix_data,
  input  logic                          frame_start,
  output logic [IDX_WIDTH+64-1:0]       data,
  output logic [63:0]                   data_mask,
  output logic                          frame_done,
  output logic [7:0]                    frame_cnt,
  output logic                          err_short,
  output logic                          err_long
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned LANE_W = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned REC_W  = IDX_WIDTH + WORD_W;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(FRAME_WORDS - 1);
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [IDX_WIDTH-1:0]   word_idx_q;
  logic [LANE_W-1:0]      lane_q;
  logic [WORD_W-1:0]      shreg_q;
  logic [WORD_W-1:0]      word_d;
  logic [REC_W-1:0]       data_q;
  logic [WORD_W-1:0]      data_mask_q;
  logic                   frame_done_q;
  logic [CNT_W-1:0]       frame_cnt_q;
  logic                   err_short_q;
  logic                   err_long_q;

  // Current word with the incoming pixel merged into its lane.
  always_comb begin
    word_d = shreg_q;
    word_d[PIX_W*int'(lane_q) +: PIX_W] = pix_data;
  end

  // Frame FSM, lane packing, word emission and error flags.
  always_ff @(posedge data_clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      word_idx_q   <= '0;
      lane_q       <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      data_mask_q  <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      data_mask_q  <= '0;
      frame_done_q <= 1'b0;
      if (frame_start) begin
        // A start in PACK abandons the partial word and the rest of the frame.
        if (state_q == S_PACK) begin
          err_short_q <= 1'b1;
        end
        state_q    <= S_PACK;
        word_idx_q <= '0;
        if (pix_valid) begin
          shreg_q[PIX_W-1:0] <= pix_data;
          lane_q             <= LANE_W'(1);
        end else begin
          lane_q <= '0;
        end
      end else begin
        case (state_q)
          S_PACK: begin
            if (pix_valid) begin
              shreg_q <= word_d;
              lane_q  <= lane_q + LANE_W'(1);
              if (lane_q == LAST_LANE) begin
                data_q      <= {word_idx_q, word_d};
                data_mask_q <= '1;
                if (word_idx_q == LAST_IDX) begin
                  frame_done_q <= 1'b1;
                  frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
                  state_q      <= S_DONE;
                  word_idx_q   <= '0;
                end else begin
                  word_idx_q <= word_idx_q + IDX_WIDTH'(1);
                end
              end
            end
          end
          S_DONE: begin
            // Pixels past the end of a frame are dropped and flagged.
            if (pix_valid) begin
              err_long_q <= 1'b1;
            end
          end
          S_IDLE: begin
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign data       = data_q;
  assign data_mask  = data_mask_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;

endmodule

// File: doc/sobel_pixel_packer.md
Name: sobel_pixel_packer

Overview:
- Sits directly upstream of the DRAM frame writer, in the data_clk domain.
- Takes the Sobel filter's 8-bit pixel stream and packs 8 consecutive pixels into one 64-bit word.
- Tags each word with a 20-bit frame-relative word index, giving the 84-bit {index, data} record plus the all-ones data_mask write qualifier that the writer consumes.
- Tracks frame boundaries and flags frames that are too short or too long.

Parameters:
- FRAME_WORDS, default 38400: 64-bit words per frame (640x480 pixels / 8). Legal range 16..2^20; must be a multiple of 16 so the writer's 16-word bursts align with frame ends.
- IDX_WIDTH, default 20: word-index width. Fixed by the 84-bit record format; not to be overridden.

Ports:
- data_clk  in  1  Sole clock; all logic on rising edge.
- rst  in  1  Reset, active-low, synchronous to data_clk.
- pix_valid  in  1  pix_data is valid this cycle.
- pix_data  in  8  Sobel magnitude pixel.
- frame_start  in  1  One-cycle pulse marking the first pixel of a frame; may coincide with pix_valid.
- data  out  84  {word_idx[19:0], packed[63:0]}; pixel k of the word is in packed[8k+7:8k].
- data_mask  out  64  64'hFFFF_FFFF_FFFF_FFFF for exactly one cycle per completed word, else 0.
- frame_done  out  1  One-cycle pulse, coincident with the data_mask pulse of the last word of a frame.
- frame_cnt  out  8  Completed-frame counter; wraps 255->0.
- err_short  out  1  Sticky: a frame_start arrived before the previous frame completed.
- err_long  out  1  Sticky: pix_valid was seen after a frame completed and before the next frame_start.

Behaviour:
- Reset (rst==0 at a posedge):
  - Registers: state=IDLE, word_idx=0, lane=0, shift register=0.
  - Outputs: data=0, data_mask=0, frame_done=0, frame_cnt=0, err_short=0, err_long=0.
  - Reset wins over every other input in that cycle.
  - Reset mid-frame discards the partial word; no mask pulse is generated.
- States:
  - IDLE: pix_valid is ignored. frame_start moves to PACK with word_idx=0 and lane=0. If pix_valid is high in the same cycle, that pixel is captured as lane 0 and lane becomes 1.
  - PACK: each pix_valid writes pix_data into lane[2:0]; lane increments.
    - When the lane-7 pixel is accepted, the next cycle presents data={word_idx, completed word} with data_mask all-ones. word_idx then increments. Latency is 1 cycle from the 8th pixel to the mask.
    - If the word just emitted has word_idx==FRAME_WORDS-1: frame_done pulses with it, frame_cnt increments, state goes to DONE, and word_idx returns to 0.
  - DONE: frame_start goes to PACK, with the same same-cycle pixel capture as IDLE. pix_valid without frame_start sets err_long; the pixel is dropped.
- frame_start while in PACK (early frame):
  - err_short is set.
  - The partial word and any remaining frame count are discarded; no mask is emitted for them.
  - Restart at word_idx=0, lane=0, capturing a same-cycle pixel as lane 0.
  - frame_cnt does not increment.
- Hold behaviour:
  - data holds its last value between mask pulses.
  - data_mask and frame_done are registered; there is no combinational path from any input.
- No back-pressure exists; the downstream FIFO sizing guarantees acceptance. Words are emitted at most one per 8 cycles.
- Gaps (pix_valid low) inside a word or frame are allowed, of any length, and do not affect packing.
- err_short and err_long clear only on reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles with pix_valid=1 -> all outputs 0. After release, pixels with no frame_start are ignored and no mask pulse occurs.
- Single word: FRAME_WORDS=16; frame_start with pix_valid, pixels 0x01..0x08 -> one cycle after 0x08, data=84'h00000_0807060504030201 and mask all-ones for exactly 1 cycle.
- Full frame with gaps: FRAME_WORDS=16, 128 pixels with random valid gaps -> 16 mask pulses with indices 0..15. frame_done coincides with index 15, frame_cnt=1, state DONE.
- Short frame: 13 pixels, then frame_start with pixel 0xAA -> err_short=1. No mask is emitted for the 5 dangling pixels. The next word has index 0 and lane-0 byte 0xAA.
- Long frame: after a full frame, 3 extra pix_valid cycles -> err_long=1 and no mask. A subsequent frame runs normally, frame_cnt=2.
- Wrap: run 256 full frames -> frame_cnt returns to 0. Assert rst mid-word -> no pulse, and all counters reset.
